srambank_ctrl_64x4x72: RTL and testbench

SRAMBANK_CTRL_64X4X72 -- requirements
Module: srambank_ctrl_64x4x72

---
 rtl/srambank_ctrl_64x4x72.sv | 124 ++++++++++++
 tb/tb_srambank_ctrl_64x4x72.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srambank_ctrl_64x4x72.sv
// srambank_ctrl_64x4x72
// Front-end for a single-port SRAM bank with a registered read port.
// Requests are forwarded to the bank combinationally on the accept cycle;
// read data comes back one cycle later, is captured into a small response
// FIFO and handed out in request order. Read credits (in-flight read plus
// FIFO occupancy) guarantee the FIFO can never overflow, so reads stall only
// when no credit is left and writes never stall.
//
// Handshake rules (both channels): a transfer happens on a rising clk edge
// when valid and ready are both high in the cycle before that edge. A source
// holding valid high keeps its payload stable until the transfer; rsp_valid
// and rsp_data stay stable while rsp_valid is high and rsp_ready is low.
module srambank_ctrl_64x4x72 #(
  parameter int AW       = 8,
  parameter int DW       = 72,
  parameter int RQ_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          bank_sel,
  output logic          bank_read,
  output logic          bank_write,
  output logic [AW-1:0] bank_addr,
  output logic [DW-1:0] bank_wd,
  input  logic [DW-1:0] bank_dataout
);

  // Pointer width; RQ_DEPTH is a power of two so pointers wrap naturally.
  localparam int PW = $clog2(RQ_DEPTH);
  // Occupancy must represent 0..RQ_DEPTH inclusive.
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          inflight_q, inflight_d;
  logic [DW-1:0] fifo_q [RQ_DEPTH];
  logic [DW-1:0] fifo_d [RQ_DEPTH];

  logic [CW:0]   outstanding;
  logic          accept;
  logic          rd_accept;
  logic          push;
  logic          pop;

  // Credit accounting: one read may be in the bank pipeline on top of the
  // entries already waiting in the FIFO.
  always_comb begin
    outstanding = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  end

  // Request side and bank drive; ready is forced low while reset is high so
  // nothing reaches the bank during reset.
  always_comb begin
    req_ready  = ~reset & (req_write | (outstanding < (CW+1)'(RQ_DEPTH)));
    accept     = req_valid & req_ready;
    rd_accept  = accept & ~req_write;
    bank_sel   = accept;
    bank_write = accept & req_write;
    bank_read  = rd_accept;
    bank_addr  = req_addr;
    bank_wd    = req_wdata;
  end

  // Response side: outputs come straight from registered FIFO state, so
  // there is no path from bank_dataout to rsp_data within a cycle.
  always_comb begin
    rsp_valid = (count_q != '0);
    rsp_data  = fifo_q[rd_ptr_q];
    push      = inflight_q;
    pop       = rsp_valid & rsp_ready;
  end

  // Next-state for the in-flight flag, FIFO storage, pointers and occupancy.
  always_comb begin
    inflight_d = rd_accept;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = bank_dataout;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // State registers; reset drops any read in flight and empties the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < RQ_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      for (int i = 0; i < RQ_DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
    end
  end

endmodule

// File: tb/tb_srambank_ctrl_64x4x72.sv
// Bench for srambank_ctrl_64x4x72: a registered-read SRAM model on the bank
// port, a response scoreboard, a table of single transactions and directed
// sequences for back-pressure, streaming, full FIFO, reset and push/pop.
module tb_srambank_ctrl_64x4x72;

  localparam int AW = 8;
  localparam int DW = 72;
  localparam int RQ_DEPTH = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          bank_sel, bank_read, bank_write;
  logic [AW-1:0] bank_addr;
  logic [DW-1:0] bank_wd;
  logic [DW-1:0] bank_dataout;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  srambank_ctrl_64x4x72 #(.AW(AW), .DW(DW), .RQ_DEPTH(RQ_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .bank_sel(bank_sel), .bank_read(bank_read), .bank_write(bank_write),
    .bank_addr(bank_addr), .bank_wd(bank_wd), .bank_dataout(bank_dataout)
  );

  // ---------------- SRAM model (registered read port) ----------------
  logic [DW-1:0] sram [0:255];
  logic [DW-1:0] sram_q;
  logic          sram_init = 1'b0;
  assign bank_dataout = sram_q;

  // Preload a byte-replicated address pattern, then model writes and reads.
  always @(posedge clk) begin
    if (!sram_init) begin
      for (int i = 0; i < 256; i++) sram[i] <= {9{i[7:0]}};
      sram_init <= 1'b1;
    end else begin
      if (bank_write) sram[bank_addr] <= bank_wd;
      if (bank_read)  sram_q <= sram[bank_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];
  int            rsp_cyc_q[$];
  int            rsp_total = 0;
  logic [DW-1:0] shadow [0:255];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Response monitor: every handshake must match the oldest expected read.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      logic [DW-1:0] e;
      rsp_total++;
      rsp_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL stray_rsp actual=%0h expected=none", rsp_data);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e);
      end
    end
    // The FIFO must never be pushed while full without a matching pop.
    if (!reset && dut.inflight_q && dut.count_q == 3'd4 && !(rsp_valid && rsp_ready)) begin
      failures++;
      $display("FAIL push_when_full actual=1 expected=0");
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int acc_cyc);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    acc_cyc = cyc;
    chk("req_accept", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (n < 100) begin
      if (w) shadow[a] = d;
      else   exp_q.push_back(shadow[a]);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          w;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_ready;
    logic          exp_bw;
    logic          exp_br;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c0, rel;
    int acc [16];
    int base;

    for (int i = 0; i < 256; i++) shadow[i] = {9{i[7:0]}};

    vecs[0] = '{1'b1, 8'h21, 72'h01_2345_6789_abcd_ef01, 1'b1, 1'b1, 1'b0, 72'h0};
    vecs[1] = '{1'b0, 8'h21, 72'h0, 1'b1, 1'b0, 1'b1, 72'h01_2345_6789_abcd_ef01};
    vecs[2] = '{1'b0, 8'h30, 72'h0, 1'b1, 1'b0, 1'b1, 72'h30_3030_3030_3030_3030};
    vecs[3] = '{1'b1, 8'hff, 72'hff_ffff_ffff_ffff_ffff, 1'b1, 1'b1, 1'b0, 72'h0};
    vecs[4] = '{1'b0, 8'hff, 72'h0, 1'b1, 1'b0, 1'b1, 72'hff_ffff_ffff_ffff_ffff};
    vecs[5] = '{1'b1, 8'h00, 72'h0, 1'b1, 1'b1, 1'b0, 72'h0};
    vecs[6] = '{1'b0, 8'h00, 72'h0, 1'b1, 1'b0, 1'b1, 72'h0};
    vecs[7] = '{1'b0, 8'h7e, 72'h0, 1'b1, 1'b0, 1'b1, 72'h7e_7e7e_7e7e_7e7e_7e7e};
    vecs[8] = '{1'b1, 8'h30, 72'h5a_5a5a_5a5a_5a5a_5a5a, 1'b1, 1'b1, 1'b0, 72'h0};
    vecs[9] = '{1'b0, 8'h30, 72'h0, 1'b1, 1'b0, 1'b1, 72'h5a_5a5a_5a5a_5a5a_5a5a};

    // ---- reset state: nothing reaches the bank, no responses ----
    repeat (3) @(posedge clk);
    #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h01;
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 72'h0);
    chk("rst_req_ready_rd", req_ready, 1'b0);
    chk("rst_bank_sel", bank_sel, 1'b0);
    chk("rst_bank_read", bank_read, 1'b0);
    req_write = 1'b1;
    #1;
    chk("rst_req_ready_wr", req_ready, 1'b0);
    chk("rst_bank_write", bank_write, 1'b0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // ---- table of single transactions, consumer always ready ----
    rsp_ready = 1'b1;
    for (int v = 0; v < 10; v++) begin
      req_valid = 1'b1; req_write = vecs[v].w;
      req_addr = vecs[v].addr; req_wdata = vecs[v].wdata;
      @(negedge clk);
      chk("tbl_req_ready", req_ready, vecs[v].exp_ready);
      chk("tbl_bank_sel", bank_sel, 1'b1);
      chk("tbl_bank_write", bank_write, vecs[v].exp_bw);
      chk("tbl_bank_read", bank_read, vecs[v].exp_br);
      chk("tbl_bank_addr", bank_addr, vecs[v].addr);
      if (vecs[v].w) chk("tbl_bank_wd", bank_wd, vecs[v].wdata);
      @(posedge clk); #1;
      if (vecs[v].w) shadow[vecs[v].addr] = vecs[v].wdata;
      else           exp_q.push_back(vecs[v].exp_rdata);
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("idle_bank_sel", bank_sel, 1'b0);
    @(posedge clk); #1;
    wait_drain();

    // ---- write then read same address on the next cycle, latency 2 ----
    rsp_cyc_q.delete();
    do_req(1'b1, 8'h05, {9{8'haa}}, c);
    do_req(1'b0, 8'h05, '0, c);
    @(negedge clk);
    chk("lat_n1_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    chk("lat_n2_rsp_valid", rsp_valid, 1'b1);
    chk("lat_n2_data", rsp_data, {9{8'haa}});
    @(posedge clk); #1;
    wait_drain();
    if (rsp_cyc_q.size() > 0) chk("lat_cycle", rsp_cyc_q[0], c + 2);
    else chk("lat_count", rsp_cyc_q.size(), 1);

    // ---- credit stall: 4 reads accepted, 5th held until a pop ----
    rsp_ready = 1'b0;
    base = rsp_total;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 8'h10 + 8'(i), '0, acc[i]);
      if (i > 0) chk("stall_b2b_accept", acc[i], acc[0] + i);
    end
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h14;
    @(negedge clk);
    chk("stall_5th_ready", req_ready, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall_hold_ready", req_ready, 1'b0);
      chk("stall_hold_valid", rsp_valid, 1'b1);
      chk("stall_hold_data", rsp_data, {9{8'h10}});
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    do_req(1'b0, 8'h14, '0, c);
    wait_drain();
    chk("stall_rsp_total", rsp_total - base, 5);

    // ---- streaming: 16 reads back to back, responses every cycle ----
    rsp_ready = 1'b1;
    rsp_cyc_q.delete();
    for (int i = 0; i < 16; i++) begin
      do_req(1'b0, 8'(i), '0, acc[i]);
    end
    wait_drain();
    chk("stream_count", rsp_cyc_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk("stream_accept_cyc", acc[i], acc[0] + i);
      if (i < rsp_cyc_q.size()) chk("stream_rsp_cyc", rsp_cyc_q[i], acc[0] + 2 + i);
    end

    // ---- FIFO full: reads stall, writes go through untouched ----
    rsp_ready = 1'b0;
    base = rsp_total;
    for (int i = 0; i < 4; i++) do_req(1'b0, 8'h60 + 8'(i), '0, c);
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h70;
    #2;
    chk("full_read_ready", req_ready, 1'b0);
    chk("full_read_sel", bank_sel, 1'b0);
    req_write = 1'b1; req_addr = 8'h60; req_wdata = {9{8'h0f}};
    @(negedge clk);
    chk("full_write_ready", req_ready, 1'b1);
    chk("full_write_bw", bank_write, 1'b1);
    chk("full_write_sel", bank_sel, 1'b1);
    chk("full_write_br", bank_read, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    shadow[8'h60] = {9{8'h0f}};
    @(negedge clk);
    chk("full_after_wr_valid", rsp_valid, 1'b1);
    chk("full_after_wr_head", rsp_data, {9{8'h60}});
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_drain();
    chk("full_rsp_total", rsp_total - base, 4);
    do_req(1'b0, 8'h60, '0, c);
    wait_drain();

    // ---- simultaneous push and pop with one entry queued ----
    rsp_ready = 1'b0;
    do_req(1'b0, 8'h21, '0, c0);
    do_req(1'b0, 8'h30, '0, c);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("pp_c2_valid", rsp_valid, 1'b1);
    @(negedge clk);
    chk("pp_c3_valid", rsp_valid, 1'b1);
    chk("pp_c3_data", rsp_data, 72'h5a_5a5a_5a5a_5a5a_5a5a);
    @(negedge clk);
    chk("pp_c4_valid", rsp_valid, 1'b0);
    @(posedge clk); #1;
    wait_drain();

    // ---- reset with one read in flight and two entries queued ----
    rsp_ready = 1'b0;
    do_req(1'b0, 8'h11, '0, c);
    do_req(1'b0, 8'h12, '0, c);
    do_req(1'b0, 8'h13, '0, c);
    #2;
    chk("pre_rst_valid", rsp_valid, 1'b1);
    reset = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h22;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    chk("midrst_req_ready", req_ready, 1'b0);
    chk("midrst_bank_sel", bank_sel, 1'b0);
    chk("midrst_bank_read", bank_read, 1'b0);
    chk("midrst_rsp_data", rsp_data, 72'h0);
    exp_q.delete();
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    rsp_cyc_q.delete();
    rel = cyc;
    #1;
    chk("release_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_q.push_back(shadow[8'h22]);
    wait_drain();
    chk("rst_new_rsp_count", rsp_cyc_q.size(), 1);
    if (rsp_cyc_q.size() > 0) chk("rst_new_rsp_cyc", rsp_cyc_q[0], rel + 2);
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_idle", rsp_valid, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
